// File: rtl/node_injector.sv
// Injection port of a network node: queues offered payloads with an acceptance
// timestamp and presents the oldest one to the network until it is taken.
module node_injector #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEST_WIDTH = 4,
   parameter int unsigned SOURCE_ID  = 0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TS_WIDTH   = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         i_data,
   input  logic [DEST_WIDTH-1:0]         i_dest,
   input  logic                          i_data_val,
   output logic                          o_en,
   output logic [DATA_WIDTH-1:0]         pkt_data,
   output logic [DEST_WIDTH-1:0]         pkt_dest,
   output logic [DEST_WIDTH-1:0]         pkt_source,
   output logic [TS_WIDTH-1:0]           pkt_timestamp,
   output logic                          pkt_valid,
   input  logic                          net_full,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic [15:0]                   o_sent_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [DEST_WIDTH-1:0] SRC = DEST_WIDTH'(SOURCE_ID);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [DEST_WIDTH-1:0] mem_dest [FIFO_DEPTH];
   logic [TS_WIDTH-1:0]   mem_ts   [FIFO_DEPTH];

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         level;
   logic [TS_WIDTH-1:0] ts_cnt;
   logic [15:0]         sent;
   logic                push;
   logic                pop;

   // o_en depends only on registered occupancy, never on this cycle's inputs
   assign o_en         = (level < DEPTH_L);
   assign pkt_valid    = (level != '0);
   assign push         = i_data_val & o_en;
   assign pop          = pkt_valid & ~net_full;
   assign o_level      = level;
   assign o_sent_count = sent;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ts_cnt <= '0;
         sent   <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (sent != '1)
               sent <= sent + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through valid pointers
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_data[wr_ptr] <= i_data;
         mem_dest[wr_ptr] <= i_dest;
         mem_ts[wr_ptr]   <= ts_cnt;
      end
   end

   always_comb begin
      pkt_data      = '0;
      pkt_dest      = '0;
      pkt_source    = '0;
      pkt_timestamp = '0;
      if (pkt_valid) begin
         pkt_data      = mem_data[rd_ptr];
         pkt_dest      = mem_dest[rd_ptr];
         pkt_source    = SRC;
         pkt_timestamp = mem_ts[rd_ptr];
      end
   end

endmodule

// File: tb/tb_node_injector.sv
// Directed + random bench for node_injector; a scoreboard queue holds the
// packets expected at the network side in order.
module tb_node_injector;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_data = '0;
   logic [3:0]  i_dest = '0;
   logic        i_data_val = 1'b0;
   logic        net_full = 1'b0;

   logic        o_en, pkt_valid;
   logic [31:0] pkt_data, pkt_timestamp;
   logic [3:0]  pkt_dest, pkt_source;
   logic [2:0]  o_level;
   logic [15:0] o_sent_count;

   logic        o_en4, p4_valid;
   logic [31:0] p4_data;
   logic [3:0]  p4_dest, p4_source, p4_ts;
   logic [2:0]  o_level4;
   logic [15:0] o_sent4;

   always #5 clk = ~clk;

   node_injector #(.DATA_WIDTH(32), .DEST_WIDTH(4), .SOURCE_ID(5), .FIFO_DEPTH(4), .TS_WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_dest(i_dest), .i_data_val(i_data_val),
      .o_en(o_en), .pkt_data(pkt_data), .pkt_dest(pkt_dest), .pkt_source(pkt_source),
      .pkt_timestamp(pkt_timestamp), .pkt_valid(pkt_valid), .net_full(net_full),
      .o_level(o_level), .o_sent_count(o_sent_count));

   node_injector #(.DATA_WIDTH(32), .DEST_WIDTH(4), .SOURCE_ID(5), .FIFO_DEPTH(4), .TS_WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .i_data(i_data), .i_dest(i_dest), .i_data_val(i_data_val),
      .o_en(o_en4), .pkt_data(p4_data), .pkt_dest(p4_dest), .pkt_source(p4_source),
      .pkt_timestamp(p4_ts), .pkt_valid(p4_valid), .net_full(net_full),
      .o_level(o_level4), .o_sent_count(o_sent4));

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  dst;
      logic [31:0] ts;
   } exp_t;

   exp_t        sb[$];
   int          m_level = 0;
   logic [31:0] m_ts = '0;
   logic [15:0] m_sent = '0;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input logic nf);
      rst = 1'b1; i_data_val = 1'b1; i_data = 32'hDEAD_BEEF; i_dest = 4'd1; net_full = nf;
      @(posedge clk); #1;
      rst = 1'b0; i_data_val = 1'b0; net_full = 1'b0;
      sb.delete(); m_level = 0; m_ts = '0; m_sent = '0;
      chk("rst_level", 64'(o_level), 64'd0);
      chk("rst_valid", 64'(pkt_valid), 64'd0);
      chk("rst_en", 64'(o_en), 64'd1);
      chk("rst_sent", 64'(o_sent_count), 64'd0);
      chk("rst_data", 64'(pkt_data), 64'd0);
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
   task automatic cycle(input logic v, input logic [31:0] d, input logic [3:0] dst, input logic nf);
      exp_t h;
      logic acc, xfer;
      i_data_val = v; i_data = d; i_dest = dst; net_full = nf;
      @(negedge clk);
      chk("level", 64'(o_level), 64'(m_level));
      chk("en", 64'(o_en), 64'(m_level < 4));
      chk("valid", 64'(pkt_valid), 64'(m_level != 0));
      chk("sent", 64'(o_sent_count), 64'(m_sent));
      chk("valid4", 64'(p4_valid), 64'(m_level != 0));
      if (m_level != 0) begin
         h = sb[0];
         chk("data", 64'(pkt_data), 64'(h.d));
         chk("dest", 64'(pkt_dest), 64'(h.dst));
         chk("source", 64'(pkt_source), 64'd5);
         chk("ts", 64'(pkt_timestamp), 64'(h.ts));
         chk("ts4", 64'(p4_ts), 64'(h.ts[3:0]));
      end else begin
         chk("idle_data", 64'(pkt_data), 64'd0);
         chk("idle_dest", 64'(pkt_dest), 64'd0);
         chk("idle_source", 64'(pkt_source), 64'd0);
         chk("idle_ts", 64'(pkt_timestamp), 64'd0);
      end
      acc  = v && (m_level < 4);
      xfer = (m_level != 0) && !nf;
      if (xfer) begin
         void'(sb.pop_front());
         if (m_sent != 16'hFFFF) m_sent++;
         m_level--;
      end
      if (acc) begin
         sb.push_back(exp_t'{d: d, dst: dst, ts: m_ts});
         m_level++;
      end
      m_ts++;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset(1'b0);

      // single packet, first cycle after reset -> timestamp 0
      cycle(1'b1, 32'hA5A5_0001, 4'd3, 1'b0);
      cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0);
      chk("single_sent", 64'(o_sent_count), 64'd1);

      // backpressure: six offers, four fit, then drain in order
      do_reset(1'b0);
      for (int i = 0; i < 6; i++)
         cycle(1'b1, 32'h1000_0000 + 32'(i), 4'(i + 2), 1'b1);
      chk("bp_level", 64'(o_level), 64'd4);
      chk("bp_en", 64'(o_en), 64'd0);
      for (int i = 0; i < 6; i++)
         cycle(1'b0, '0, '0, 1'b0);
      chk("bp_sent", 64'(o_sent_count), 64'd4);

      // simultaneous accept and transfer at level 2
      do_reset(1'b0);
      cycle(1'b1, 32'h2000_0001, 4'd1, 1'b1);
      cycle(1'b1, 32'h2000_0002, 4'd2, 1'b1);
      cycle(1'b1, 32'h2000_0003, 4'd3, 1'b0);
      chk("sim_level", 64'(o_level), 64'd2);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, '0, '0, 1'b0);

      // full queue: offer during transfer is dropped
      do_reset(1'b0);
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'h3000_0000 + 32'(i), 4'(i), 1'b1);
      cycle(1'b1, 32'h3BAD_BAD0, 4'd9, 1'b0);
      chk("full_level", 64'(o_level), 64'd3);
      chk("full_en", 64'(o_en), 64'd1);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, '0, '0, 1'b0);

      // reset mid-operation with level 3 and network blocked
      do_reset(1'b0);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h4000_0000 + 32'(i), 4'(i), 1'b1);
      chk("pre_rst_level", 64'(o_level), 64'd3);
      do_reset(1'b1);
      cycle(1'b1, 32'h4444_0000, 4'd4, 1'b0);
      cycle(1'b0, '0, '0, 1'b0);

      // timestamp wrap on the 4-bit build: offers at counts 15 and 16
      do_reset(1'b0);
      for (int i = 0; i < 15; i++)
         cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b1, 32'h5000_000F, 4'd7, 1'b1);
      cycle(1'b1, 32'h5000_0010, 4'd8, 1'b1);
      chk("wrap_ts4_first", 64'(p4_ts), 64'd15);
      cycle(1'b0, '0, '0, 1'b0);
      chk("wrap_ts4_second", 64'(p4_ts), 64'd0);
      cycle(1'b0, '0, '0, 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0));
      for (int i = 0; i < 6; i++)
         cycle(1'b0, '0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/node_injector.md
NODE_INJECTOR -- requirements
Module: node_injector

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 Parameter DEST_WIDTH, default 4, destination node index width.
REQ-003 Parameter SOURCE_ID, default 0, node index stamped into every packet, DEST_WIDTH bits.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two >= 2, injection queue entries.
REQ-005 Parameter TS_WIDTH, default 32, timestamp width.
REQ-006 The block SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 i_data  input  DATA_WIDTH  payload from traffic source.
REQ-010 i_dest  input  DEST_WIDTH  destination node of offered payload.
REQ-011 i_data_val  input  1  traffic source offers i_data/i_dest this cycle.
REQ-012 o_en  output  1  block can accept an offer this cycle.
REQ-013 pkt_data  output  DATA_WIDTH  payload presented to network.
REQ-014 pkt_dest  output  DEST_WIDTH  destination presented to network.
REQ-015 pkt_source  output  DEST_WIDTH  equals SOURCE_ID while pkt_valid is high.
REQ-016 pkt_timestamp  output  TS_WIDTH  cycle count captured at acceptance.
REQ-017 pkt_valid  output  1  packet fields are valid.
REQ-018 net_full  input  1  network cannot take a packet from this node this cycle.
REQ-019 o_level  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-020 o_sent_count  output  16  packets transferred into network, saturating.

Function
REQ-021 Accept: offer taken at a rising edge iff i_data_val=1 and o_en=1 in the preceding cycle; no other condition pushes.
REQ-022 o_en SHALL equal (o_level < FIFO_DEPTH), derived only from registered state, no combinational path from net_full or i_data_val.
REQ-023 Timestamp counter: TS_WIDTH bits, +1 every cycle, wraps from all-ones to 0; accepted entry stores counter value of the accepting cycle.
REQ-024 Queue is first-in first-out; pkt_data/pkt_dest/pkt_timestamp show the head entry; pkt_valid = (o_level != 0).
REQ-025 When pkt_valid=0, pkt_data, pkt_dest, pkt_source, pkt_timestamp SHALL be 0.
REQ-026 Transfer: occurs in any cycle with pkt_valid=1 and net_full=0; head popped at that edge; o_sent_count increments, saturating at 16'hFFFF.
REQ-027 While net_full=1, head entry and all pkt_* outputs SHALL hold stable; no entry is dropped or reordered.
REQ-028 Latency: offer accepted into empty queue at edge N -> pkt_valid=1 with that packet in the cycle following edge N; single-cycle minimum.
REQ-029 Simultaneous accept and transfer: o_level unchanged, new entry enqueued behind remaining ones.
REQ-030 Full queue: o_en=0; offer ignored even if a transfer occurs the same cycle; o_en returns 1 the cycle after that transfer.
REQ-031 Pointers wrap modulo FIFO_DEPTH; o_level counts 0..FIFO_DEPTH inclusive.
REQ-032 net_full while pkt_valid=0 SHALL have no effect.

Reset
REQ-033 On rst=1 at a rising edge: o_level=0, pointers=0, timestamp counter=0, o_sent_count=0; next cycle pkt_valid=0, pkt_* fields=0, o_en=1.
REQ-034 Reset mid-operation discards all queued packets; an offer coincident with rst is not accepted; a transfer coincident with rst is not counted.
REQ-035 First cycle after reset release stamps timestamp 0.

Verification
REQ-036 Reset, then one offer i_data=32'hA5A5_0001, i_dest=3, net_full=0 -> next cycle pkt_valid=1, pkt_dest=3, pkt_source=SOURCE_ID, pkt_timestamp=0; following cycle pkt_valid=0, o_sent_count=1.
REQ-037 net_full=1 held, 6 consecutive offers (DEPTH 4) -> 4 accepted, o_en=0 after 4th, o_level=4; release net_full -> 4 packets out in order, timestamps 0,1,2,3, o_sent_count=4.
REQ-038 o_level=2, simultaneous offer and transfer -> o_level stays 2, FIFO order preserved.
REQ-039 Full queue, offer plus transfer same cycle -> offer dropped, o_level=3, o_en=1 next cycle.
REQ-040 rst asserted with o_level=3 and net_full=1 -> next cycle pkt_valid=0, o_level=0, o_sent_count=0, timestamp restarts at 0.
REQ-041 Force counter near wrap (TS_WIDTH=4 build): offers at counts 15 and next -> pkt_timestamp 15 then 0.
